// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB-first, one start bit, one stop bit.
//   Line is synchronised through two flops, start bits are validated at mid-bit,
//   data bits are sampled at mid-bit, and each good byte is presented with a
//   single-cycle rx_valid strobe. A zero stop bit pulses frame_err and the
//   receiver then waits for the line to return high before re-arming.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
//   the data bits and the stop bit, plus the parity_err output.
// Ports:
//   clk        - single rising-edge clock
//   reset_n    - asynchronous active-low reset
//   rx         - asynchronous serial input, idles high
//   rx_data    - last good byte, held until the next good frame
//   rx_valid   - one-cycle pulse when rx_data updates
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   parity_err - (UART_RX_PARITY_EN only) one-cycle pulse on parity mismatch
//   busy       - high in every state except IDLE
//   s1, s0     - state encoding for debug
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned BAUD_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output logic                 s1,
  output logic                 s0
);

  localparam int unsigned TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  // PARITY reads as 10 on {s1,s0}; the third bit only separates it from DATA.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_STOP   = 3'b011,
    ST_PARITY = 3'b110
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;
`endif

  logic                 r_sync1, r_rx_s;
  state_t               r_state, w_state_nx;
  logic [TW-1:0]        r_tick_cnt, w_tick_nx;
  logic [SW-1:0]        r_samp_cnt, w_samp_nx;
  logic [BW-1:0]        r_bit_cnt, w_bit_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic [DATA_BITS-1:0] r_data, w_data_nx;
  logic                 r_valid, w_valid_nx;
  logic                 r_ferr, w_ferr_nx;
  logic                 r_busy, w_busy_nx;
  logic                 r_wait_high, w_wait_nx;
  logic                 r_stop_done, w_stop_done_nx;
  logic                 r_stop_bit, w_stop_bit_nx;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad, w_par_bad_nx;
  logic                 r_perr, w_perr_nx;
`endif

  logic w_tick, w_mid, w_end;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TW'(BAUD_DIV - 1));
  assign w_mid  = w_tick && (r_samp_cnt == SW'(OVERSAMPLE / 2 - 1));
  assign w_end  = w_tick && (r_samp_cnt == SW'(OVERSAMPLE - 1));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nx     = r_state;
    w_tick_nx      = w_tick ? '0 : r_tick_cnt + TW'(1);
    w_samp_nx      = r_samp_cnt;
    w_bit_nx       = r_bit_cnt;
    w_shift_nx     = r_shift;
    w_data_nx      = r_data;
    w_valid_nx     = 1'b0;
    w_ferr_nx      = 1'b0;
    w_wait_nx      = r_wait_high;
    w_stop_done_nx = r_stop_done;
    w_stop_bit_nx  = r_stop_bit;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nx   = r_par_bad;
    w_perr_nx      = 1'b0;
`endif
    if (w_tick) begin
      w_samp_nx = (r_samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : r_samp_cnt + SW'(1);
    end

    case (r_state)
      ST_IDLE: begin
        w_tick_nx      = '0;
        w_samp_nx      = '0;
        w_bit_nx       = '0;
        w_stop_done_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nx   = 1'b0;
`endif
        // After a framing error the line must be seen high before re-arming.
        if (r_wait_high) begin
          if (r_rx_s) w_wait_nx = 1'b0;
        end else if (!r_rx_s) begin
          w_state_nx = ST_START;
        end
      end
      ST_START: begin
        if (w_mid) begin
          if (r_rx_s) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_DATA;
            w_samp_nx  = '0;
          end
        end
      end
      ST_DATA: begin
        if (w_end) begin
          w_shift_nx = {r_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
            w_bit_nx   = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nx = ST_PARITY;
`else
            w_state_nx = ST_STOP;
`endif
          end else begin
            w_bit_nx = r_bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_end) begin
          w_par_bad_nx = r_rx_s ^ (^r_shift);
          w_state_nx   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Sample at the bit boundary, then issue the strobe one cycle later.
        if (r_stop_done) begin
          w_stop_done_nx = 1'b0;
          w_state_nx     = ST_IDLE;
          if (r_stop_bit) begin
`ifdef UART_RX_PARITY_EN
            w_perr_nx = r_par_bad;
            if (!r_par_bad) begin
              w_valid_nx = 1'b1;
              w_data_nx  = r_shift;
            end
`else
            w_valid_nx = 1'b1;
            w_data_nx  = r_shift;
`endif
          end else begin
            w_ferr_nx = 1'b1;
            w_wait_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_nx = r_par_bad;
`endif
          end
        end else if (w_end) begin
          w_stop_done_nx = 1'b1;
          w_stop_bit_nx  = r_rx_s;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
      r_wait_high <= 1'b0;
      r_stop_done <= 1'b0;
      r_stop_bit  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_tick_cnt  <= w_tick_nx;
      r_samp_cnt  <= w_samp_nx;
      r_bit_cnt   <= w_bit_nx;
      r_shift     <= w_shift_nx;
      r_data      <= w_data_nx;
      r_valid     <= w_valid_nx;
      r_ferr      <= w_ferr_nx;
      r_busy      <= w_busy_nx;
      r_wait_high <= w_wait_nx;
      r_stop_done <= w_stop_done_nx;
      r_stop_bit  <= w_stop_bit_nx;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= w_par_bad_nx;
      r_perr      <= w_perr_nx;
`endif
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif
  assign busy      = r_busy;
  assign s1        = r_state[1];
  assign s0        = r_state[0];

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at default parameters (B = 64 clocks
//   per bit). Expected strobes are queued when a frame is driven and popped
//   when the receiver strobes. Cycle numbers count rising clk edges; a value
//   "at E+n" is sampled on the falling edge following rising edge E+n.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned B = 64;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned STROBE_OFS = 675;
`else
  localparam int unsigned STROBE_OFS = 611;
`endif

  typedef struct {
    logic [2:0]  kind;   // {rx_valid, frame_err, parity_err}
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy, s1, s0;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned pa_cyc, pb_cyc;
  logic [2:0]  pa_val, pb_val;
  int          checks = 0;
  int          failures = 0;

  uart_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy),
    .s1        (s1),
    .s0        (s0)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to the next falling edge, record probes and score any strobe.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (cyc == pa_cyc) pa_val = {busy, s1, s0};
    if (cyc == pb_cyc) pb_val = {busy, s1, s0};
    if (rx_valid || frame_err || parity_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({rx_valid, frame_err, parity_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind",  32'({rx_valid, frame_err, parity_err}), 32'(e.kind));
        chk("strobe_data",  32'(rx_data), 32'(e.data));
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  endtask

  // Drive one full frame starting at the current falling edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input logic [2:0] kind, input logic [7:0] exp_data,
                            output int unsigned e_cyc);
    e_cyc  = cyc + 1;
    pa_cyc = e_cyc + STROBE_OFS - 1;
    pb_cyc = e_cyc + STROBE_OFS + 1;
    sb.push_back('{kind: kind, data: exp_data, cyc: e_cyc + STROBE_OFS});
    rx = 1'b0;
    repeat (B) step();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) step();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (B) step();
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_b;
    repeat (B) step();
  endtask

  initial begin
    int unsigned e, e1, e2;
    int          bad;
    reset_n = 1'b0;
    rx      = 1'b1;
    pa_cyc  = '1;
    pb_cyc  = '1;
    pa_val  = '0;
    pb_val  = '0;

    // Reset state, then a quiet idle line.
    repeat (3) step();
    chk("reset_outputs", 32'({rx_data, rx_valid, frame_err, parity_err, busy, s1, s0}), 32'd0);
    reset_n = 1'b1;
    bad = 0;
    repeat (200) begin
      step();
      if ({rx_data, rx_valid, frame_err, parity_err, busy, s1, s0} !== 14'd0) bad++;
    end
    chk("idle_200", 32'(bad), 32'd0);

    // Good frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0, 3'b100, 8'hA5, e);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_busy_stop_before_strobe", 32'(pa_val), 32'b111);
    chk("a5_idle_after_strobe", 32'(pb_val), 32'b000);
    repeat (10) step();

    // Glitch: 20 low clocks is rejected at the mid-bit check.
    e  = cyc + 1;
    rx = 1'b0;
    repeat (20) step();
    rx = 1'b1;
    while (cyc < e + 33) step();
    chk("glitch_still_start", 32'({busy, s1, s0}), 32'b101);
    step();
    chk("glitch_back_idle", 32'({busy, s1, s0}), 32'b000);
    repeat (700) step();

    // Frame 0x3C with a zero stop bit, line then held low (break).
    send_frame(8'h3C, 1'b0, 1'b0, 3'b010, 8'hA5, e);
    bad = 0;
    repeat (300) begin
      step();
      if ({busy, s1, s0} !== 3'b000) bad++;
    end
    chk("break_no_restart", 32'(bad), 32'd0);
    chk("ferr_data_held", 32'(rx_data), 32'hA5);
    rx = 1'b1;
    repeat (10) step();
    chk("break_released_idle", 32'({busy, s1, s0}), 32'b000);

    // Back-to-back frames, second start bit right after the first stop bit.
    send_frame(8'h00, 1'b1, 1'b0, 3'b100, 8'h00, e1);
    send_frame(8'hFF, 1'b1, 1'b0, 3'b100, 8'hFF, e2);
    chk("b2b_last_data", 32'(rx_data), 32'hFF);
    repeat (20) step();

    // Asynchronous reset mid-frame discards the partial frame.
    e  = cyc + 1;
    rx = 1'b0;
    repeat (B) step();
    rx = 1'b1;
    while (cyc < e + 299) step();
    chk("midframe_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", 32'({rx_data, rx_valid, frame_err, parity_err, busy, s1, s0}), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();

    send_frame(8'h5A, 1'b1, 1'b0, 3'b100, 8'h5A, e);
    chk("5a_data", 32'(rx_data), 32'h5A);
    repeat (10) step();

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: parity_err only, data held.
    send_frame(8'h5A, 1'b1, 1'b1, 3'b001, 8'h5A, e);
    chk("parity_bad_data_held", 32'(rx_data), 32'h5A);
    repeat (10) step();
`endif

    repeat (50) step();
    chk("all_strobes_seen", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side counterpart of the UART transmit path. It oversamples the asynchronous serial line `rx`, detects and validates start bits, and shifts in an LSB-first data frame. It checks the stop bit and presents each received byte with a single-cycle valid strobe. It sits between the pad-side serial input and the parallel consumer logic, and exposes its state bits (`s1`,`s0`) for debug in the same way as the transmit FSM.

## Interface
- `DATA_BITS`, 8: data bits per frame (5..8).
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥4.
- `BAUD_DIV`, 4: clk cycles per sample tick (≥1).

- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `rx` input, 1 bit: serial line; idles high; asynchronous to `clk`.
- `rx_data` output, DATA_BITS bits: last good byte; holds until the next good frame.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` updates.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled 0.
- `busy` output, 1 bit: high in every state except IDLE.
- `s1`, `s0` output, 1 bit each: state encoding.

## Operation
- `rx` passes through a 2-flop synchronizer; `rx_s` is the second flop. The synchronizer resets to 1.
- Tick generator: counter 0..BAUD_DIV-1; `tick` is asserted when the counter is at BAUD_DIV-1. The counter is cleared on start detection.
- Sample counter: 0..OVERSAMPLE-1, advances on `tick`. Bit counter: 0..DATA_BITS-1.
- States (`{s1,s0}`):
  - IDLE = 00
  - START = 01
  - DATA = 10
  - STOP = 11
- IDLE: on `rx_s` == 0, go to START. Clear the tick, sample and bit counters.
- START: at sample count OVERSAMPLE/2-1 (mid-bit):
  - `rx_s` == 1: false start; return to IDLE with no strobe.
  - `rx_s` == 0: go to DATA and clear the sample count. All later samples fall at mid-bit.
- DATA: every OVERSAMPLE ticks, shift `rx_s` into the MSB of the shift register (right shift, LSB first). After DATA_BITS samples, go to STOP.
- STOP: after OVERSAMPLE ticks, sample `rx_s`:
  - 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - 0: pulse `frame_err`, leave `rx_data` unchanged, go to IDLE. IDLE does not re-arm until `rx_s` has been observed high for one cycle (break handling).
- A start edge arriving during the cycle STOP returns to IDLE is caught the next cycle. There is no dead time beyond that cycle.
- `rx_valid` and `frame_err` are never asserted in the same cycle.

## Timing
- Reset values: state IDLE; `rx_data` = 0; `rx_valid` = 0; `frame_err` = 0; `busy` = 0; `s1` = `s0` = 0; all counters 0. Reset takes effect immediately and asynchronously from any state, including mid-frame. A partial frame is discarded with no strobe.
- Let B = OVERSAMPLE×BAUD_DIV clocks per bit, and let edge cycle E be the clk edge at which the first synchronizer flop captures 0.
  - START at E+2.
  - Start mid-bit sample at E+2+B/2.
  - Data bit k sampled at E+2+B/2+(k+1)×B.
  - `rx_valid`/`frame_err` high during the cycle after the stop sample: E+3+B/2+(DATA_BITS+1)×B.
- Defaults (B=64): strobe at E+611; `busy` high from E+2 through E+610.
- Outputs are registered; there are no combinational paths from `rx` to any output.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: adds state PARITY (encoding held in an internal third state bit; `{s1,s0}` reads 10 during PARITY) between DATA and STOP. PARITY samples one bit and compares it with the even parity of the data. Adds output `parity_err` (1 bit, reset 0), a one-cycle pulse coincident with the strobe slot. On parity error, `rx_valid` is suppressed and `rx_data` is held. All strobes shift by B (E+675 at defaults).
  - Undefined: no PARITY state, no `parity_err` port, frame = start + DATA_BITS + stop.

## Test plan
- Reset with `rx`=1, then release: all outputs 0 and `{s1,s0}`=00 for 200 cycles with no strobe.
- Frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) at defaults: `rx_data`=0xA5; `rx_valid` high exactly one cycle at E+611; `busy` low at E+612.
- Glitch: `rx` low for 20 clocks, then high: return to IDLE at E+34 with no `rx_valid` or `frame_err`.
- Frame 0x3C with stop bit 0: `frame_err` pulses once at E+611; `rx_data` keeps its previous value 0xA5. While `rx` stays low, no new frame starts until `rx` goes high.
- Back-to-back frames 0x00 then 0xFF, with the second start bit immediately after the first stop bit: two `rx_valid` pulses 640 cycles apart carrying 0x00 then 0xFF.
- `reset_n` asserted at E+300 mid-frame: outputs go to reset values immediately, with no strobe. The next full frame 0x5A is received correctly. With `UART_RX_PARITY_EN`, frame 0x5A with parity bit 1 gives `parity_err` at E+675 and no `rx_valid`.
